// File: rtl/player_vmotion.sv
// Vertical-motion controller for the player sprite: grounded, jump rise,
// gravity fall and ladder-follow, landing on the four platform heights.
module player_vmotion #(
    parameter int unsigned JUMP_HEIGHT = 48,
    parameter int unsigned RISE_STEP   = 4,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned MAX_FALL    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        jump_req,
    input  logic        ladder_active,
    input  logic [11:0] ladder_ypos,
    output logic [11:0] ypos,
    output logic [1:0]  level,
    output logic        airborne,
    output logic        land_pulse
);

    localparam int unsigned YW = 12;
    localparam int unsigned SW = 5;

    localparam logic [YW-1:0] LANDING_POS_1 = 12'd644;
    localparam logic [YW-1:0] LANDING_POS_2 = 12'd479;
    localparam logic [YW-1:0] LANDING_POS_3 = 12'd302;
    localparam logic [YW-1:0] LANDING_POS_4 = 12'd175;

    typedef enum logic [1:0] {GROUNDED, RISE, FALL, LADDER} state_t;

    state_t        state, state_n;
    logic [YW-1:0] ypos_n, apex, apex_n;
    logic [1:0]    level_n, near_idx;
    logic          airborne_n, land_n, jump_latch, latch_n;
    logic [SW-1:0] speed, speed_n;
    logic [SW:0]   speed_inc;
    logic [YW:0]   fall_sum;
    logic signed [YW:0] rise_y;
    logic [YW-1:0] target, best_d, cur_d;

    function automatic logic [YW-1:0] landing_pos(input logic [1:0] idx);
        case (idx)
            2'd0:    landing_pos = LANDING_POS_1;
            2'd1:    landing_pos = LANDING_POS_2;
            2'd2:    landing_pos = LANDING_POS_3;
            default: landing_pos = LANDING_POS_4;
        endcase
    endfunction

    function automatic logic [YW-1:0] abs_diff(input logic [YW-1:0] a, input logic [YW-1:0] b);
        abs_diff = (a >= b) ? (a - b) : (b - a);
    endfunction

    // Nearest landing height to the last sampled ladder position; strict < keeps ties on the lower index.
    always_comb begin
        near_idx = 2'd0;
        best_d   = abs_diff(ypos, LANDING_POS_1);
        cur_d    = '0;
        for (int n = 1; n < 4; n++) begin
            cur_d = abs_diff(ypos, landing_pos(2'(n)));
            if (cur_d < best_d) begin
                best_d   = cur_d;
                near_idx = 2'(n);
            end
        end
    end

    always_comb begin
        state_n   = state;
        ypos_n    = ypos;
        level_n   = level;
        apex_n    = apex;
        speed_n   = speed;
        latch_n   = jump_latch;
        land_n    = 1'b0;
        target    = landing_pos(level);
        rise_y    = $signed({1'b0, ypos}) - $signed((YW+1)'(RISE_STEP));
        fall_sum  = {1'b0, ypos} + (YW+1)'(speed);
        speed_inc = (SW+1)'(speed) + (SW+1)'(GRAVITY);

        if (frame_tick) latch_n = 1'b0;

        case (state)
            GROUNDED: begin
                if (ladder_active) begin
                    state_n = LADDER;
                    latch_n = 1'b0;
                end else begin
                    if (frame_tick && jump_latch) begin
                        state_n = RISE;
                        apex_n  = (ypos >= YW'(JUMP_HEIGHT)) ? (ypos - YW'(JUMP_HEIGHT)) : '0;
                    end else if (jump_req) begin
                        latch_n = 1'b1;
                    end
                end
            end
            RISE: begin
                if (frame_tick) begin
                    if (rise_y <= $signed({1'b0, apex})) begin
                        ypos_n  = apex;
                        speed_n = SW'(GRAVITY);
                        state_n = FALL;
                    end else begin
                        ypos_n = ypos - YW'(RISE_STEP);
                    end
                end
            end
            FALL: begin
                // Landing check uses the pre-increment speed.
                if (frame_tick) begin
                    if (fall_sum >= {1'b0, target}) begin
                        ypos_n  = target;
                        state_n = GROUNDED;
                        land_n  = 1'b1;
                    end else begin
                        ypos_n  = ypos + YW'(speed);
                        speed_n = (speed_inc > (SW+1)'(MAX_FALL)) ? SW'(MAX_FALL) : SW'(speed_inc);
                    end
                end
            end
            default: begin
                if (ladder_active) begin
                    ypos_n = ladder_ypos;
                end else begin
                    level_n = near_idx;
                    ypos_n  = landing_pos(near_idx);
                    state_n = GROUNDED;
                end
            end
        endcase

        airborne_n = (state_n == RISE) || (state_n == FALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GROUNDED;
            ypos       <= LANDING_POS_1;
            level      <= 2'd0;
            airborne   <= 1'b0;
            land_pulse <= 1'b0;
            speed      <= '0;
            jump_latch <= 1'b0;
            apex       <= '0;
        end else begin
            state      <= state_n;
            ypos       <= ypos_n;
            level      <= level_n;
            airborne   <= airborne_n;
            land_pulse <= land_n;
            speed      <= speed_n;
            jump_latch <= latch_n;
            apex       <= apex_n;
        end
    end

endmodule

// File: tb/tb_player_vmotion.sv
// Scoreboard bench for player_vmotion: stimulus pushes expected outputs,
// a monitor pops and compares them on the falling clock edge.
module tb_player_vmotion;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        jump_req = 1'b0;
    logic        ladder_active = 1'b0;
    logic [11:0] ladder_ypos = 12'd0;
    logic [11:0] ypos;
    logic [1:0]  level;
    logic        airborne;
    logic        land_pulse;

    player_vmotion dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .jump_req      (jump_req),
        .ladder_active (ladder_active),
        .ladder_ypos   (ladder_ypos),
        .ypos          (ypos),
        .level         (level),
        .airborne      (airborne),
        .land_pulse    (land_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] y;
        logic [1:0]  lvl;
        logic        air;
        logic        lp;
        int          lands;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    vec_cnt  = 0;
    int    miss_cnt = 0;
    int    land_cnt = 0;
    int    exp_lands = 0;

    // Monitor: counts observed landing pulses and checks one queued vector per cycle.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (land_pulse === 1'b1) land_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                vec_cnt++;
                if (ypos !== e.y || level !== e.lvl || airborne !== e.air ||
                    land_pulse !== e.lp || land_cnt != e.lands) begin
                    miss_cnt++;
                    $display("FAIL %s: got ypos=%0d level=%0d airborne=%0b land_pulse=%0b lands=%0d, want ypos=%0d level=%0d airborne=%0b land_pulse=%0b lands=%0d",
                             t, ypos, level, airborne, land_pulse, land_cnt,
                             e.y, e.lvl, e.air, e.lp, e.lands);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vec_cnt);
        $fatal(1, "timeout");
    end

    task automatic push(input string t, input logic [11:0] y, input logic [1:0] l,
                        input logic a, input logic p);
        exp_t e;
        e.y = y; e.lvl = l; e.air = a; e.lp = p; e.lands = exp_lands;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
    endtask

    task automatic pulse_jump();
        @(posedge clk); #1 jump_req = 1'b1;
        @(posedge clk); #1 jump_req = 1'b0;
    endtask

    // Full jump from a grounded height; nfall < 10 stops partway through the fall.
    task automatic run_jump(input int base, input logic [1:0] lvl, input bit noise, input int nfall);
        int fd[9] = '{1, 3, 6, 10, 15, 21, 28, 36, 44};
        pulse_jump();
        tick();
        push("launch", 12'(base), lvl, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            if (noise && i == 5) pulse_jump();
            tick();
            push($sformatf("rise%0d", i), 12'(base - 4*i), lvl, 1'b1, 1'b0);
        end
        for (int j = 0; j < 9 && j < nfall; j++) begin
            if (noise && j == 3) pulse_jump();
            tick();
            push($sformatf("fall%0d", j + 1), 12'(base - 48 + fd[j]), lvl, 1'b1, 1'b0);
        end
        if (nfall >= 10) begin
            tick();
            exp_lands++;
            push("land", 12'(base), lvl, 1'b0, 1'b1);
            @(posedge clk); #1;
            push("land_done", 12'(base), lvl, 1'b0, 1'b0);
        end
    endtask

    task automatic ladder_visit(input logic [11:0] ly, input logic [1:0] lvl_before,
                                input logic [11:0] exp_y, input logic [1:0] exp_l);
        ladder_ypos = ly;
        @(posedge clk); #1 ladder_active = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        push($sformatf("ladder_follow_%0d", ly), ly, lvl_before, 1'b0, 1'b0);
        @(negedge clk); ladder_active = 1'b0;
        @(posedge clk); #1;
        push($sformatf("ladder_exit_%0d", ly), exp_y, exp_l, 1'b0, 1'b0);
    endtask

    initial begin
        #1 push("reset_hold", 12'd644, 2'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            tick();
            push($sformatf("idle%0d", k), 12'd644, 2'd0, 1'b0, 1'b0);
        end

        run_jump(644, 2'd0, 1'b0, 10);
        run_jump(644, 2'd0, 1'b1, 10);

        // Reset asserted mid-fall at ypos 611.
        run_jump(644, 2'd0, 1'b0, 5);
        @(negedge clk); #2 rst_n = 1'b0;
        #1 push("reset_async", 12'd644, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        push("post_reset", 12'd644, 2'd0, 1'b0, 1'b0);

        // Ladder request and jump latch coincide on one tick: ladder wins.
        ladder_ypos = 12'd485;
        pulse_jump();
        @(posedge clk); #1 frame_tick = 1'b1; ladder_active = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        push("ladder_enter", 12'd644, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        push("ladder_follow_485", 12'd485, 2'd0, 1'b0, 1'b0);
        @(negedge clk); ladder_active = 1'b0;
        @(posedge clk); #1;
        push("ladder_exit_485", 12'd479, 2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        push("no_jump_after_ladder", 12'd479, 2'd1, 1'b0, 1'b0);

        ladder_visit(12'd390, 2'd1, 12'd302, 2'd2);
        ladder_visit(12'd0,   2'd2, 12'd175, 2'd3);

        run_jump(175, 2'd3, 1'b0, 10);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miss_cnt++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
